acc_exec_unit: RTL and testbench
================================

Name: acc_exec_unit

Overview:
- Sequencing stage that wraps the 16-bit add/sub ALU.
- Accepts one instruction at a time over a valid/ready handshake and fetches the B operand (immediate or data memory).
- Drives the ALU's A/B/Op inputs, consumes its combinational result into the accumulator, and reports completion and flags.
- Sits between the instruction decoder (upstream) and the ALU (downstream); it owns the accumulator.

Parameters:
DATA_W, 16, datapath width; must match the ALU width.
ADDR_W, 11, data-memory address width; address is operand[ADDR_W-1:0].

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  instruction present.
in_ready  output  1  block can accept an instruction this cycle.
in_opcode  input  3  operation code, encoding below.
in_operand  input  DATA_W  immediate value or memory address.
mem_rd  output  1  data-memory read strobe, one cycle.
mem_addr  output  ADDR_W  read address, valid while mem_rd=1.
mem_rdata  input  DATA_W  read data, valid the cycle after mem_rd (synchronous RAM).
alu_a  output  DATA_W  to ALU A; always equals acc.
alu_b  output  DATA_W  to ALU B; equals the latched operand register.
alu_op  output  1  to ALU Op; 0 = add, 1 = subtract.
alu_out  input  DATA_W  from ALU Out (combinational).
acc  output  DATA_W  accumulator.
zero  output  1  acc == 0, registered with acc.
neg  output  1  acc[DATA_W-1], registered with acc.
done  output  1  one-cycle completion pulse.

Behaviour:
- Opcodes: 000 NOP, 001 LDI, 010 LD, 011 ADDI, 100 ADD, 101 SUBI, 110 SUB, 111 reserved (executes as NOP).
- Reset values: state=IDLE, acc=0, zero=1, neg=0, operand reg=0, alu_op=0, mem_rd=0, mem_addr=0, done=0.
  - in_ready is 1 after reset.
- FSM states: IDLE, MEM_RD, MEM_WAIT, EXEC, DONE.
- in_ready = (state==IDLE); it is combinational from state only.
- Accept occurs at a rising edge with in_valid=1 and in_ready=1. The accept edge latches the opcode and operand, then branches:
  - LDI: acc<=operand at the accept edge -> DONE.
  - NOP/reserved -> DONE; acc unchanged.
  - ADDI/SUBI: operand reg<=operand, alu_op<=(SUBI) -> EXEC.
  - LD/ADD/SUB: mem_addr<=operand[ADDR_W-1:0] -> MEM_RD; alu_op<=(SUB).
- MEM_RD: mem_rd=1 for exactly this cycle -> MEM_WAIT.
- MEM_WAIT: mem_rdata is sampled at the end of the cycle.
  - LD: acc<=mem_rdata -> DONE.
  - ADD/SUB: operand reg<=mem_rdata -> EXEC.
- EXEC: alu_a/alu_b/alu_op are stable for the whole cycle; acc<=alu_out at the end of the cycle -> DONE.
- DONE: done=1 for exactly one cycle; acc, zero and neg already hold the new value -> IDLE.
- Latency from accept edge to the done cycle:
  - NOP/LDI: 1 cycle.
  - ADDI/SUBI: 2 cycles.
  - LD: 3 cycles.
  - ADD/SUB: 4 cycles.
- Throughput: the next accept happens at earliest on the edge ending the cycle after DONE (IDLE is mandatory).
- Arithmetic: modulo 2^DATA_W wrap performed by the ALU; no carry or overflow flag.
  - zero and neg are updated on every acc write and only then.
- in_valid while busy: ignored, no side effects; the upstream holds the instruction until in_ready=1.
  - Inputs may change freely while in_ready=0.
- mem_addr holds its last value outside MEM_RD; the memory must ignore it when mem_rd=0.
- Reset asserted in any state immediately forces the reset values.
  - The in-flight instruction is discarded: no done and no acc update.
  - An outstanding memory read's data is ignored.
- No instruction is accepted during the reset-release cycle's edge if reset is still high at that edge.

Test Plan:
- Reset, then LDI 0x1234 -> done 1 cycle after accept, acc=0x1234, zero=0, neg=0; then ADDI 0x0001 -> alu_a=0x1234, alu_b=0x0001, alu_op=0 during EXEC; acc=0x1235 at done (2 cycles after accept).
- acc=0x0000, SUBI 0x0001 -> acc=0xFFFF, neg=1, zero=0; then ADDI 0x0001 -> acc=0x0000, zero=1 (wrap both ways).
- Memory model with mem[0x005]=0x7FFF, acc=0x0001, ADD 0x0005 -> mem_rd high exactly 1 cycle with mem_addr=0x005; acc=0x8000, neg=1; done 4 cycles after accept.
- LD 0x07FF with mem[0x7FF]=0xBEEF -> acc=0xBEEF at done (3 cycles), alu_out ignored; SUB from mem[0x010]=0x0001 -> acc=0xBEEE.
- in_valid held high continuously with a stream ADDI 1, ADDI 2, NOP, opcode 111 -> each accepted only when in_ready=1, exactly one done per instruction, final acc=prior+3.
- Reset asserted during MEM_WAIT of ADD -> outputs return to reset values immediately, no done; after release, in_ready=1 and LDI 0x0042 executes normally.

Source files
------------

// File: rtl/acc_exec_unit.sv
// acc_exec_unit
//   Sequencing stage around a 16-bit add/sub ALU. Accepts one instruction at a
//   time (valid/ready), fetches the B operand from the immediate or from a
//   synchronous data memory, drives the ALU and writes its result into the
//   accumulator, then pulses done.
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   in_valid/in_ready     instruction handshake; in_ready = (state==IDLE)
//   in_opcode/in_operand  instruction fields
//   mem_rd/mem_addr       one-cycle read strobe + address to data memory
//   mem_rdata             read data, valid the cycle after mem_rd
//   alu_a/alu_b/alu_op    ALU inputs (acc, operand reg, 0=add 1=sub)
//   alu_out               combinational ALU result
//   acc/zero/neg          accumulator and its flags
//   done                  one-cycle completion pulse
module acc_exec_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_opcode,
    input  logic [DATA_W-1:0] in_operand,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_op,
    input  logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] acc,
    output logic              zero,
    output logic              neg,
    output logic              done
);
    localparam logic [2:0] OP_LDI  = 3'b001;
    localparam logic [2:0] OP_LD   = 3'b010;
    localparam logic [2:0] OP_ADDI = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUBI = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;

    typedef enum logic [2:0] {S_IDLE, S_MEM_RD, S_MEM_WAIT, S_EXEC, S_DONE} state_t;

    state_t            r_state;
    logic [2:0]        r_opc;
    logic [DATA_W-1:0] r_opnd;
    logic [DATA_W-1:0] r_acc;
    logic              r_zero;
    logic              r_neg;
    logic              r_alu_op;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_done;

    logic              w_accept;
    logic              w_acc_we;
    logic [DATA_W-1:0] w_acc_d;

    assign in_ready = (r_state == S_IDLE);
    assign w_accept = in_valid && in_ready;

    assign mem_rd   = r_mem_rd;
    assign mem_addr = r_mem_addr;
    assign alu_a    = r_acc;
    assign alu_b    = r_opnd;
    assign alu_op   = r_alu_op;
    assign acc      = r_acc;
    assign zero     = r_zero;
    assign neg      = r_neg;
    assign done     = r_done;

    // Single accumulator write port; flags follow every write and only then.
    always_comb begin
        w_acc_we = 1'b0;
        w_acc_d  = alu_out;
        case (r_state)
            S_IDLE: begin
                if (w_accept && in_opcode == OP_LDI) begin
                    w_acc_we = 1'b1;
                    w_acc_d  = in_operand;
                end
            end
            S_MEM_WAIT: begin
                if (r_opc == OP_LD) begin
                    w_acc_we = 1'b1;
                    w_acc_d  = mem_rdata;
                end
            end
            S_EXEC: w_acc_we = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_opc      <= '0;
            r_opnd     <= '0;
            r_acc      <= '0;
            r_zero     <= 1'b1;
            r_neg      <= 1'b0;
            r_alu_op   <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_done     <= 1'b0;
        end else begin
            // Strobes are single-cycle; set only on the transition into their state.
            r_mem_rd <= 1'b0;
            r_done   <= 1'b0;

            if (w_acc_we) begin
                r_acc  <= w_acc_d;
                r_zero <= (w_acc_d == '0);
                r_neg  <= w_acc_d[DATA_W-1];
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_opc <= in_opcode;
                        case (in_opcode)
                            OP_ADDI, OP_SUBI: begin
                                r_opnd   <= in_operand;
                                r_alu_op <= (in_opcode == OP_SUBI);
                                r_state  <= S_EXEC;
                            end
                            OP_LD, OP_ADD, OP_SUB: begin
                                r_mem_addr <= in_operand[ADDR_W-1:0];
                                r_mem_rd   <= 1'b1;
                                r_alu_op   <= (in_opcode == OP_SUB);
                                r_state    <= S_MEM_RD;
                            end
                            // LDI (acc written above), NOP and reserved
                            default: begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                        endcase
                    end
                end
                S_MEM_RD: r_state <= S_MEM_WAIT;
                S_MEM_WAIT: begin
                    if (r_opc == OP_LD) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_opnd  <= mem_rdata;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_exec_unit.sv
module tb_acc_exec_unit;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_opcode = '0;
    logic [DATA_W-1:0] in_operand = '0;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [DATA_W-1:0] alu_a, alu_b, alu_out, acc;
    logic              alu_op, zero, neg, done;

    acc_exec_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_operand(in_operand), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_out(alu_out), .acc(acc), .zero(zero), .neg(neg),
        .done(done)
    );

    always #5 clk = ~clk;

    // ALU and synchronous data memory
    assign alu_out = alu_op ? (alu_a - alu_b) : (alu_a + alu_b);
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_W-1:0] acc;
        int                lat;
        int                start;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int failures = 0;
    int n_push = 0;
    int n_done = 0;

    // Monitor: every done pops one expected completion
    always @(negedge clk) begin
        if (!reset && done) begin
            n_done++;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done acc=%h (no instruction outstanding)", acc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (acc !== e.acc || zero !== (e.acc == 0) || neg !== e.acc[DATA_W-1]) begin
                    failures++;
                    $display("FAIL result acc=%h z=%b n=%b expected acc=%h z=%b n=%b",
                             acc, zero, neg, e.acc, (e.acc == 0), e.acc[DATA_W-1]);
                end
                checks++;
                if (cyc - e.start != e.lat) begin
                    failures++;
                    $display("FAIL latency got=%0d expected=%0d", cyc - e.start, e.lat);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Issue one instruction; returns just after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [DATA_W-1:0] opnd,
                         input logic [DATA_W-1:0] exp_acc, input int lat,
                         input bit push, input bit hold);
        int n;
        in_valid   = 1'b1;
        in_opcode  = op;
        in_operand = opnd;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout op=%b", op);
        end
        if (push) begin
            q.push_back('{acc: exp_acc, lat: lat, start: cyc});
            n_push++;
        end
        @(posedge clk); #1;
        in_valid = hold;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((q.size() != 0 || !in_ready) && n < 50);
        if (q.size() != 0 || !in_ready) begin
            checks++; failures++;
            $display("FAIL idle_timeout pending=%0d in_ready=%b", q.size(), in_ready);
        end
    endtask

    initial begin
        mem[11'h005] = 16'h7FFF;
        mem[11'h7FF] = 16'hBEEF;
        mem[11'h010] = 16'h0001;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_state", {in_ready, acc, zero, neg, done, mem_rd, mem_addr, alu_op, alu_b},
            {1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 16'h0000});
        @(negedge clk); reset = 1'b0;
        @(negedge clk); #1;

        // LDI then ADDI, with EXEC-cycle ALU drive check
        issue(3'b001, 16'h1234, 16'h1234, 1, 1, 0);
        wait_idle();
        issue(3'b011, 16'h0001, 16'h1235, 2, 1, 0);
        @(negedge clk);
        chk("exec_alu_inputs", {alu_a, alu_b, alu_op}, {16'h1234, 16'h0001, 1'b0});
        wait_idle();

        // wrap both ways
        issue(3'b001, 16'h0000, 16'h0000, 1, 1, 0);
        wait_idle();
        issue(3'b101, 16'h0001, 16'hFFFF, 2, 1, 0);
        wait_idle();
        issue(3'b011, 16'h0001, 16'h0000, 2, 1, 0);
        wait_idle();

        // ADD from memory, mem_rd exactly one cycle
        issue(3'b001, 16'h0001, 16'h0001, 1, 1, 0);
        wait_idle();
        issue(3'b100, 16'h0005, 16'h8000, 4, 1, 0);
        @(negedge clk);
        chk("mem_rd_pulse", {mem_rd, mem_addr}, {1'b1, 11'h005});
        @(negedge clk);
        chk("mem_rd_single", {29'd0, mem_rd}, 30'd0);
        wait_idle();

        // LD top address, then SUB from memory
        issue(3'b010, 16'h07FF, 16'hBEEF, 3, 1, 0);
        wait_idle();
        issue(3'b110, 16'h0010, 16'hBEEE, 4, 1, 0);
        wait_idle();

        // streaming with in_valid held high
        issue(3'b001, 16'h0100, 16'h0100, 1, 1, 0);
        wait_idle();
        issue(3'b011, 16'h0001, 16'h0101, 2, 1, 1);
        issue(3'b011, 16'h0002, 16'h0103, 2, 1, 1);
        issue(3'b000, 16'hFFFF, 16'h0103, 1, 1, 1);
        issue(3'b111, 16'hAAAA, 16'h0103, 1, 1, 0);
        wait_idle();
        chk("stream_final_acc", acc, 16'h0103);

        // reset during MEM_WAIT of ADD
        issue(3'b001, 16'h0055, 16'h0055, 1, 1, 0);
        wait_idle();
        issue(3'b100, 16'h0005, 16'h0000, 4, 0, 0);
        @(negedge clk);   // MEM_RD
        @(negedge clk);   // MEM_WAIT
        reset = 1'b1;
        #1;
        chk("reset_abort", {in_ready, acc, zero, neg, done, mem_rd, mem_addr, alu_op, alu_b},
            {1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 16'h0000});
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("post_reset_idle", {in_ready, acc, done}, {1'b1, 16'h0000, 1'b0});
        issue(3'b001, 16'h0042, 16'h0042, 1, 1, 0);
        wait_idle();

        repeat (3) @(negedge clk);
        #1;
        chk("done_count", n_done, n_push);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
